chroma_keyer: RTL and testbench



---
 rtl/greenscreen_pkg.sv | 20 ++
 rtl/chroma_key_compare.sv | 73 +++++++
 rtl/chroma_keyer.sv | 166 ++++++++++++++++
 tb/tb_chroma_keyer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/greenscreen_pkg.sv
// Shared definitions for the green-screen keying path: mode encodings,
// default component width and a packed RGB pixel type.
package greenscreen_pkg;

  localparam int GS_DATA_W = 12;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_SOLID  = 2'd1,
    MODE_CHECK  = 2'd2,
    MODE_MASK   = 2'd3
  } mode_e;

  typedef struct packed {
    logic [GS_DATA_W-1:0] r;
    logic [GS_DATA_W-1:0] g;
    logic [GS_DATA_W-1:0] b;
  } rgb_t;

endpackage

// File: rtl/chroma_key_compare.sv
// Pipeline stages 1-2: margin add, then green-dominance compare. The pixel,
// its valid and an opaque sideband word are delayed to stay aligned with key_o.
module chroma_key_compare
  import greenscreen_pkg::*;
#(
  parameter int DATA_W = GS_DATA_W,
  parameter int SIDE_W = 1
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DATA_W-1:0] red_i,
  input  logic [DATA_W-1:0] green_i,
  input  logic [DATA_W-1:0] blue_i,
  input  logic              valid_i,
  input  logic [SIDE_W-1:0] side_i,
  input  logic [DATA_W-1:0] margin_i,
  input  logic [DATA_W-1:0] min_green_i,
  output logic [DATA_W-1:0] red_o,
  output logic [DATA_W-1:0] green_o,
  output logic [DATA_W-1:0] blue_o,
  output logic              valid_o,
  output logic [SIDE_W-1:0] side_o,
  output logic              key_o
);

  logic [DATA_W:0]   sum_r_d, sum_b_d, sum_r_q, sum_b_q;
  logic [DATA_W-1:0] red1_q, green1_q, blue1_q;
  logic              valid1_q;
  logic [SIDE_W-1:0] side1_q;
  logic              key_d;

  // Sums carry one extra bit so a large margin can never wrap into a false key.
  always_comb begin
    sum_r_d = {1'b0, red_i} + {1'b0, margin_i};
    sum_b_d = {1'b0, blue_i} + {1'b0, margin_i};
    key_d   = ({1'b0, green1_q} >= sum_r_q) &&
              ({1'b0, green1_q} >= sum_b_q) &&
              (green1_q >= min_green_i);
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sum_r_q  <= '0;
      sum_b_q  <= '0;
      red1_q   <= '0;
      green1_q <= '0;
      blue1_q  <= '0;
      valid1_q <= 1'b0;
      side1_q  <= '0;
      red_o    <= '0;
      green_o  <= '0;
      blue_o   <= '0;
      valid_o  <= 1'b0;
      side_o   <= '0;
      key_o    <= 1'b0;
    end else begin
      sum_r_q  <= sum_r_d;
      sum_b_q  <= sum_b_d;
      red1_q   <= red_i;
      green1_q <= green_i;
      blue1_q  <= blue_i;
      valid1_q <= valid_i;
      side1_q  <= side_i;
      red_o    <= red1_q;
      green_o  <= green1_q;
      blue_o   <= blue1_q;
      valid_o  <= valid1_q;
      side_o   <= side1_q;
      key_o    <= key_d;
    end
  end

endmodule

// File: rtl/chroma_keyer.sv
// Green-screen keyer: classifies each pixel, substitutes a background chosen
// by the per-frame mode, and reports the keyed-pixel count of each frame.
module chroma_keyer
  import greenscreen_pkg::*;
#(
  parameter int DATA_W      = GS_DATA_W,
  parameter int H_ACTIVE    = 640,
  parameter int CNT_W       = 20,
  parameter int CHECK_SHIFT = 4
) (
  input  logic                iCLK,
  input  logic                iRST,
  input  logic [DATA_W-1:0]   iRed,
  input  logic [DATA_W-1:0]   iGreen,
  input  logic [DATA_W-1:0]   iBlue,
  input  logic                iDataValid,
  input  logic                iFrameValid,
  input  logic [1:0]          iMode,
  input  logic [DATA_W-1:0]   iMargin,
  input  logic [DATA_W-1:0]   iMinGreen,
  input  logic [3*DATA_W-1:0] iBgColor,
  output logic [DATA_W-1:0]   oRed,
  output logic [DATA_W-1:0]   oGreen,
  output logic [DATA_W-1:0]   oBlue,
  output logic                oDataValid,
  output logic                oFrameValid,
  output logic [CNT_W-1:0]    oKeyCount,
  output logic                oKeyCountValid
);

  localparam int X_W    = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int Y_W    = 10;
  localparam int SIDE_W = 4;
  localparam logic [X_W-1:0] X_LAST = X_W'(H_ACTIVE - 1);

  logic           fv_hist_q, frame_rise;
  logic [X_W-1:0] x_q, x_d, x_cur;
  logic [Y_W-1:0] y_q, y_d, y_cur;
  mode_e          mode_q, mode_cur;
  logic [SIDE_W-1:0] side_s0, side_s2;

  // A rising frame edge clears position and latches the mode in the same
  // cycle, so the first pixel of a frame already sees x=0, y=0 and the new mode.
  always_comb begin
    frame_rise = iFrameValid & ~fv_hist_q;
    x_cur      = frame_rise ? '0 : x_q;
    y_cur      = frame_rise ? '0 : y_q;
    mode_cur   = frame_rise ? mode_e'(iMode) : mode_q;
    x_d        = x_cur;
    y_d        = y_cur;
    if (iDataValid) begin
      if (x_cur == X_LAST) begin
        x_d = '0;
        y_d = y_cur + Y_W'(1);
      end else begin
        x_d = x_cur + X_W'(1);
      end
    end
    side_s0 = {iFrameValid, mode_cur, x_cur[CHECK_SHIFT] ^ y_cur[CHECK_SHIFT]};
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      fv_hist_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      mode_q    <= MODE_BYPASS;
    end else begin
      fv_hist_q <= iFrameValid;
      x_q       <= x_d;
      y_q       <= y_d;
      mode_q    <= mode_cur;
    end
  end

  logic [DATA_W-1:0] red_s2, green_s2, blue_s2;
  logic              valid_s2, key_s2;

  chroma_key_compare #(
    .DATA_W (DATA_W),
    .SIDE_W (SIDE_W)
  ) u_compare (
    .clk_i       (iCLK),
    .srst_i      (iRST),
    .red_i       (iRed),
    .green_i     (iGreen),
    .blue_i      (iBlue),
    .valid_i     (iDataValid),
    .side_i      (side_s0),
    .margin_i    (iMargin),
    .min_green_i (iMinGreen),
    .red_o       (red_s2),
    .green_o     (green_s2),
    .blue_o      (blue_s2),
    .valid_o     (valid_s2),
    .side_o      (side_s2),
    .key_o       (key_s2)
  );

  logic               fv_s2, chk_s2;
  mode_e              mode_s2;
  logic [3*DATA_W-1:0] pix_d, pix_q;

  assign fv_s2   = side_s2[3];
  assign mode_s2 = mode_e'(side_s2[2:1]);
  assign chk_s2  = side_s2[0];

  always_comb begin
    pix_d = {red_s2, green_s2, blue_s2};
    if (key_s2) begin
      case (mode_s2)
        MODE_SOLID: pix_d = iBgColor;
        MODE_CHECK: pix_d = chk_s2 ? '1 : '0;
        MODE_MASK:  pix_d = '0;
        default:    pix_d = {red_s2, green_s2, blue_s2};
      endcase
    end else if (mode_s2 == MODE_MASK) begin
      pix_d = '1;
    end
    if (!valid_s2) pix_d = '0;
  end

  logic             valid_q, key_q, fv_q, fv_out_hist_q, kcv_q, key_inc, frame_fall;
  logic [CNT_W-1:0] count_q, count_sum, count_d, kc_q;

  // The pixel leaving stage 3 in the falling-edge cycle still belongs to the
  // total being reported.
  always_comb begin
    key_inc    = valid_q & key_q;
    frame_fall = fv_out_hist_q & ~fv_q;
    count_sum  = count_q;
    if (key_inc && (count_q != '1)) count_sum = count_q + CNT_W'(1);
    count_d    = frame_fall ? '0 : count_sum;
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      pix_q         <= '0;
      valid_q       <= 1'b0;
      key_q         <= 1'b0;
      fv_q          <= 1'b0;
      fv_out_hist_q <= 1'b0;
      count_q       <= '0;
      kc_q          <= '0;
      kcv_q         <= 1'b0;
    end else begin
      pix_q         <= pix_d;
      valid_q       <= valid_s2;
      key_q         <= key_s2;
      fv_q          <= fv_s2;
      fv_out_hist_q <= fv_q;
      count_q       <= count_d;
      kcv_q         <= frame_fall;
      if (frame_fall) kc_q <= count_sum;
    end
  end

  assign oRed           = pix_q[3*DATA_W-1 -: DATA_W];
  assign oGreen         = pix_q[2*DATA_W-1 -: DATA_W];
  assign oBlue          = pix_q[DATA_W-1:0];
  assign oDataValid     = valid_q;
  assign oFrameValid    = fv_q;
  assign oKeyCount      = kc_q;
  assign oKeyCountValid = kcv_q;

endmodule

// File: tb/tb_chroma_keyer.sv
// Scoreboard bench for chroma_keyer: the driver queues expected pixels and
// frame counts, and an independent monitor checks them as the DUT emits them.
module tb_chroma_keyer;
  import greenscreen_pkg::*;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic [11:0] iRed = '0, iGreen = '0, iBlue = '0;
  logic        iDataValid = 1'b0, iFrameValid = 1'b0;
  logic [1:0]  iMode = 2'd0;
  logic [11:0] iMargin = '0, iMinGreen = '0;
  logic [35:0] iBgColor = '0;
  logic [11:0] oRed, oGreen, oBlue;
  logic        oDataValid, oFrameValid, oKeyCountValid;
  logic [19:0] oKeyCount;

  chroma_keyer dut (
    .iCLK(iCLK), .iRST(iRST), .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .iDataValid(iDataValid), .iFrameValid(iFrameValid), .iMode(iMode),
    .iMargin(iMargin), .iMinGreen(iMinGreen), .iBgColor(iBgColor),
    .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue), .oDataValid(oDataValid),
    .oFrameValid(oFrameValid), .oKeyCount(oKeyCount), .oKeyCountValid(oKeyCountValid)
  );

  always #5 iCLK = ~iCLK;

  int cyc = 0;
  always @(posedge iCLK) cyc <= cyc + 1;

  typedef struct { rgb_t pix; int cyc; } exp_t;
  exp_t sq[$];
  int   kq[$];
  int   checks = 0, errors = 0;
  bit   fv_log [0:32767];
  bit   fv_prev = 1'b0;
  int   m_mode = 0, m_x = 0, m_y = 0, acc = 0;

  function automatic rgb_t mk(input int r, input int g, input int b);
    rgb_t p;
    p.r = r[11:0];
    p.g = g[11:0];
    p.b = b[11:0];
    return p;
  endfunction

  function automatic bit model_key(input rgb_t p, input int margin, input int ming);
    int r, g, b;
    r = int'(p.r); g = int'(p.g); b = int'(p.b);
    return (g >= r + margin) && (g >= b + margin) && (g >= ming);
  endfunction

  function automatic rgb_t model_out(input int mode, input bit key, input bit chk,
                                     input rgb_t p, input rgb_t bg);
    rgb_t o;
    o = p;
    if (mode == 3) o = key ? '0 : '1;
    else if (key && mode == 1) o = bg;
    else if (key && mode == 2) o = chk ? '1 : '0;
    return o;
  endfunction

  function automatic rgb_t key_pix(input int i);
    return mk(i % 64, 900, 20);
  endfunction

  function automatic rgb_t fg_pix(input int i);
    return mk(550, 600, i % 256);
  endfunction

  task automatic drive(input bit fv, input bit dv, input rgb_t p,
                       input bit use_exp, input rgb_t exp_pix, input bit exp_key);
    bit   key, chk;
    rgb_t e;
    @(posedge iCLK); #1;
    iFrameValid = fv; iDataValid = dv;
    iRed = p.r; iGreen = p.g; iBlue = p.b;
    fv_log[cyc] = fv;
    if (fv && !fv_prev) begin
      m_mode = int'(iMode); m_x = 0; m_y = 0;
    end
    if (dv) begin
      if (use_exp) begin
        key = exp_key; e = exp_pix;
      end else begin
        key = model_key(p, int'(iMargin), int'(iMinGreen));
        chk = (((m_x >> 4) ^ (m_y >> 4)) & 1) != 0;
        e   = model_out(m_mode, key, chk, p, rgb_t'(iBgColor));
      end
      sq.push_back('{e, cyc});
      if (key) acc++;
      m_x++;
      if (m_x == 640) begin
        m_x = 0; m_y = (m_y + 1) % 1024;
      end
    end
    if (!fv && fv_prev) begin
      kq.push_back(acc); acc = 0;
    end
    fv_prev = fv;
  endtask

  task automatic idle(input bit fv, input int n);
    rgb_t z;
    z = '0;
    repeat (n) drive(fv, 1'b0, z, 1'b0, z, 1'b0);
  endtask

  task automatic pix(input rgb_t p);
    drive(1'b1, 1'b1, p, 1'b0, p, 1'b0);
  endtask

  task automatic pix_exp(input rgb_t p, input rgb_t e, input bit k);
    drive(1'b1, 1'b1, p, 1'b1, e, k);
    idle(1'b1, 3);
  endtask

  task automatic do_reset();
    @(posedge iCLK); #1;
    iRST = 1'b1; iFrameValid = 1'b0; iDataValid = 1'b0;
    while (sq.size() > 0 && sq[$].cyc >= cyc - 2) void'(sq.pop_back());
    for (int k = cyc - 2; k <= cyc; k++) if (k >= 0) fv_log[k] = 1'b0;
    acc = 0; fv_prev = 1'b0;
    @(posedge iCLK); #1;
    fv_log[cyc] = 1'b0;
    @(negedge iCLK);
    checks++;
    if ({oRed, oGreen, oBlue} !== 36'd0 || oDataValid !== 1'b0 || oFrameValid !== 1'b0 ||
        oKeyCount !== 20'd0 || oKeyCountValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got rgb=%h dv=%b fv=%b kc=%0d kcv=%b want all zero",
               {oRed, oGreen, oBlue}, oDataValid, oFrameValid, oKeyCount, oKeyCountValid);
    end
    @(posedge iCLK); #1;
    iRST = 1'b0;
    fv_log[cyc] = 1'b0;
  endtask

  // Monitor
  exp_t mon_e;
  int   mon_want;
  int   fall_cyc = -10;
  bit   last_ofv = 1'b0;
  always @(negedge iCLK) begin
    if (cyc >= 3) begin
      checks++;
      if (oFrameValid !== fv_log[cyc-3]) begin
        errors++;
        $display("FAIL frame_valid cyc=%0d got %b want %b", cyc, oFrameValid, fv_log[cyc-3]);
      end
      if (oDataValid === 1'b1) begin
        checks++;
        if (sq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pixel cyc=%0d got %h want no pixel", cyc, {oRed, oGreen, oBlue});
        end else begin
          mon_e = sq.pop_front();
          if ({oRed, oGreen, oBlue} !== mon_e.pix || cyc - mon_e.cyc != 3) begin
            errors++;
            $display("FAIL pixel cyc=%0d got %h latency %0d want %h latency 3",
                     cyc, {oRed, oGreen, oBlue}, cyc - mon_e.cyc, mon_e.pix);
          end else begin
            $display("pixel cyc=%0d out=%h ok", cyc, {oRed, oGreen, oBlue});
          end
        end
      end else begin
        checks++;
        if ({oRed, oGreen, oBlue} !== 36'd0) begin
          errors++;
          $display("FAIL idle_colour cyc=%0d got %h want 0", cyc, {oRed, oGreen, oBlue});
        end
      end
      if (oKeyCountValid === 1'b1) begin
        checks++;
        if (kq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_count_pulse cyc=%0d got %0d want no pulse", cyc, oKeyCount);
        end else begin
          mon_want = kq.pop_front();
          if (oKeyCount !== 20'(mon_want) || cyc != fall_cyc + 1) begin
            errors++;
            $display("FAIL key_count cyc=%0d got %0d at fall+%0d want %0d at fall+1",
                     cyc, oKeyCount, cyc - fall_cyc, mon_want);
          end else begin
            $display("key_count cyc=%0d count=%0d ok", cyc, oKeyCount);
          end
        end
      end
      if (last_ofv && !oFrameValid) fall_cyc = cyc;
      last_ofv = oFrameValid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Directed keying and overflow vectors, solid background
    iMode = 2'd1; iMargin = 12'd100; iMinGreen = 12'd200;
    iBgColor = {12'h00A, 12'h00B, 12'h00C};
    idle(1'b0, 2);
    idle(1'b1, 1);
    pix_exp(mk(50, 400, 60), mk(12'h00A, 12'h00B, 12'h00C), 1'b1);
    pix_exp(mk(350, 400, 60), mk(350, 400, 60), 1'b0);
    iMargin = 12'd1; iMinGreen = 12'd0;
    pix_exp(mk(12'hFFF, 12'hFFF, 0), mk(12'hFFF, 12'hFFF, 0), 1'b0);
    iMargin = 12'hFFF;
    pix_exp(mk(0, 12'hFFF, 0), mk(12'h00A, 12'h00B, 12'h00C), 1'b1);
    idle(1'b0, 6);

    // Single-cycle frame with no data
    idle(1'b1, 1);
    idle(1'b0, 6);

    // 640x4 frame with 1000 keyed pixels, then a fresh frame with a mid-frame mode change
    iMargin = 12'd100; iMinGreen = 12'd200;
    for (int i = 0; i < 2560; i++) pix(i < 1000 ? key_pix(i) : fg_pix(i));
    idle(1'b0, 6);
    for (int i = 0; i < 640; i++) begin
      if (i == 320) iMode = 2'd3;
      pix((i % 5 == 0) ? key_pix(i) : fg_pix(i));
    end
    idle(1'b0, 6);
    for (int i = 0; i < 640; i++) pix((i % 5 == 0) ? key_pix(i) : fg_pix(i));
    idle(1'b0, 6);

    // Checkerboard over 17 lines, every pixel keyed
    iMode = 2'd2;
    for (int i = 0; i < 640 * 17; i++) pix(key_pix(i));
    idle(1'b0, 6);

    // Reset in the middle of a frame, then a clean frame
    iMode = 2'd1;
    for (int i = 0; i < 500; i++) pix(key_pix(i));
    do_reset();
    idle(1'b0, 2);
    for (int i = 0; i < 640; i++) pix(i < 200 ? key_pix(i) : fg_pix(i));
    idle(1'b0, 10);

    checks++;
    if (sq.size() != 0) begin
      errors++;
      $display("FAIL pixels_drained got %0d pending want 0", sq.size());
    end
    checks++;
    if (kq.size() != 0) begin
      errors++;
      $display("FAIL counts_drained got %0d pending want 0", kq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
